// File: rtl/lcd_draw_sequencer.sv
// Command FIFO plus two-phase draw sequencer in front of LCD_RUN: window setup, pixel burst,
// enforced inter-draw gap and a per-phase watchdog with a sticky error flag.
module lcd_draw_sequencer #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        cmd_valid,
   input  logic [30:0]                 cmd_data,
   output logic                        cmd_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [30:0]                 LCD_CRTL,
   output logic                        sel,
   output logic                        position_en,
   output logic                        data_en,
   input  logic                        position_finish,
   input  logic                        Initial_finish,
   output logic                        busy,
   output logic                        draw_done,
   output logic                        timeout_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [19:0]   WD_LAST  = 20'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StPos, StData, StGap} state_e;

   state_e          state_q, state_d;
   logic [30:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            cmd_ready_q;
   logic [30:0]     crtl_q;
   logic [19:0]     wd_q;
   logic [3:0]      gap_q;
   logic            sel_q;
   logic            draw_done_q;
   logic            timeout_err_q;

   logic            push, pop;
   logic            wd_clr, wd_expired;
   logic            gap_met;
   logic            done_set, to_set;

   // ---------------------------------------------------------------- command FIFO
   assign push = cmd_valid && cmd_ready_q;
   assign pop  = (state_q == StIdle) && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= cmd_data;
      end
   end

   // Pointers are exactly AW bits wide, so natural overflow gives the modulo-depth wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q     <= count_d;
         cmd_ready_q <= (count_d < DEPTH_C);
      end
   end

   // ---------------------------------------------------------------- draw FSM
   assign wd_expired = (wd_q == WD_LAST);
   assign gap_met    = (gap_q >= GAP_LAST);

   always_comb begin
      state_d  = state_q;
      wd_clr   = 1'b0;
      done_set = 1'b0;
      to_set   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            state_d = StPos;
            wd_clr  = 1'b1;
         end
         StPos: begin
            if (position_finish) begin
               state_d = StData;
               wd_clr  = 1'b1;
            end else if (wd_expired) begin
               state_d = StGap;
               to_set  = 1'b1;
            end
         end
         StData: begin
            if (Initial_finish) begin
               state_d  = StGap;
               done_set = 1'b1;
            end else if (wd_expired) begin
               state_d = StGap;
               to_set  = 1'b1;
            end
         end
         StGap: begin
            // A finish still high from LCD_RUN would be mistaken for the next draw's completion.
            if (gap_met && !position_finish && !Initial_finish) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_q <= '0;
      end else if (wd_clr) begin
         wd_q <= '0;
      end else if ((state_q == StPos) || (state_q == StData)) begin
         wd_q <= wd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gap_q <= '0;
      end else if (state_q != StGap) begin
         gap_q <= '0;
      end else if (gap_q != 4'hF) begin
         gap_q <= gap_q + 1'b1;
      end
   end

   // sel only moves on state transitions, so it reads 0 out of reset until the first draw.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel_q <= 1'b0;
      end else if (state_d != state_q) begin
         sel_q <= (state_d == StIdle) || (state_d == StLoad) || (state_d == StPos);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         crtl_q        <= '0;
         draw_done_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         if (pop) begin
            crtl_q <= mem_q[rd_ptr_q];
         end
         draw_done_q   <= done_set;
         timeout_err_q <= timeout_err_q || to_set;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign cmd_ready   = cmd_ready_q;
   assign fifo_count  = count_q;
   assign LCD_CRTL    = crtl_q;
   assign sel         = sel_q;
   assign position_en = (state_q == StPos);
   assign data_en     = (state_q == StData);
   assign busy        = (state_q != StIdle) || (count_q != '0);
   assign draw_done   = draw_done_q;
   assign timeout_err = timeout_err_q;

endmodule
